// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: supervisor state encoding and counter width helper.
package pll_sup_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FALLBACK} state_t;
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser.
// Ports: clk destination clock, rst_n async active-low reset, d async input, q synchronised output.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_supervisor_rst_seq.sv
// pll_supervisor_rst_seq: SB_PLL40 reset/lock supervisor with staged system resets and bypass fallback.
// Ports: REFERENCECLK clock, RESET async active-low reset, PLL_LOCK async lock, FORCE_RESTART restart pulse,
//        PLL_RESETB/PLL_BYPASS PLL controls, SYS_RESETN staged resets (bit 0 first), READY in RUN,
//        FAULT in FALLBACK, RETRY_CNT failed attempts, LOSS_CNT saturating lock-loss count.
module pll_supervisor_rst_seq
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 12,
  parameter int LOCK_TIMEOUT_CYCLES = 1200,
  parameter int LOCK_STABLE_CYCLES  = 120,
  parameter int RST_STRETCH_CYCLES  = 16,
  parameter int RST_STAGE_GAP       = 4,
  parameter int NUM_RST             = 2,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               REFERENCECLK,
  input  logic               RESET,
  input  logic               PLL_LOCK,
  input  logic               FORCE_RESTART,
  output logic               PLL_RESETB,
  output logic               PLL_BYPASS,
  output logic [NUM_RST-1:0] SYS_RESETN,
  output logic               READY,
  output logic               FAULT,
  output logic [3:0]         RETRY_CNT,
  output logic [7:0]         LOSS_CNT
);
  localparam int STAGE_END = RST_STRETCH_CYCLES + (NUM_RST - 1) * RST_STAGE_GAP;
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, STAGE_END);
  state_t st;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_RST-1:0] rel_n;
  logic [3:0] retry_n;
  logic lock_s;
  sync_2ff u_lock_sync (.clk(REFERENCECLK), .rst_n(RESET), .d(PLL_LOCK), .q(lock_s));
  // stage counter parks on the last release point; release mask is for the value it moves to
  assign cnt_n = (cnt == CW'(STAGE_END)) ? cnt : cnt + CW'(1);
  assign retry_n = RETRY_CNT + 4'd1;
  always_comb begin
    rel_n = '0;
    for (int i = 0; i < NUM_RST; i++) rel_n[i] = cnt_n >= CW'(RST_STRETCH_CYCLES + i * RST_STAGE_GAP);
  end
  always_ff @(posedge REFERENCECLK or negedge RESET)
    if (!RESET) begin
      st <= PLL_RST;
      cnt <= '0;
      PLL_RESETB <= 1'b0;
      PLL_BYPASS <= 1'b0;
      SYS_RESETN <= '0;
      READY <= 1'b0;
      FAULT <= 1'b0;
      RETRY_CNT <= '0;
      LOSS_CNT <= '0;
    end else if (FORCE_RESTART) begin
      st <= PLL_RST;
      cnt <= '0;
      PLL_RESETB <= 1'b0;
      PLL_BYPASS <= 1'b0;
      SYS_RESETN <= '0;
      READY <= 1'b0;
      FAULT <= 1'b0;
      RETRY_CNT <= '0;
    end else
      case (st)
        PLL_RST:
          if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
            st <= WAIT_LOCK;
            cnt <= '0;
            PLL_RESETB <= 1'b1;
          end else cnt <= cnt + CW'(1);
        WAIT_LOCK:
          if (lock_s) begin
            st <= STABLE;
            cnt <= '0;
          end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            cnt <= '0;
            RETRY_CNT <= retry_n;
            if (retry_n == 4'(MAX_RETRIES)) begin
              st <= FALLBACK;
              PLL_BYPASS <= 1'b1;
              FAULT <= 1'b1;
            end else begin
              st <= PLL_RST;
              PLL_RESETB <= 1'b0;
            end
          end else cnt <= cnt + CW'(1);
        STABLE:
          if (!lock_s) begin
            st <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            st <= RUN;
            cnt <= '0;
            READY <= 1'b1;
            RETRY_CNT <= '0;
          end else cnt <= cnt + CW'(1);
        RUN:
          if (!lock_s) begin
            st <= PLL_RST;
            cnt <= '0;
            PLL_RESETB <= 1'b0;
            SYS_RESETN <= '0;
            READY <= 1'b0;
            if (LOSS_CNT != 8'hFF) LOSS_CNT <= LOSS_CNT + 8'd1;
          end else begin
            cnt <= cnt_n;
            SYS_RESETN <= rel_n;
          end
        FALLBACK: begin
          cnt <= cnt_n;
          SYS_RESETN <= rel_n;
        end
        default: st <= PLL_RST;
      endcase
endmodule

// File: tb/tb_pll_supervisor_rst_seq.sv
// tb_pll_supervisor_rst_seq: directed scenario bench for pll_supervisor_rst_seq.
`timescale 1ns/1ps
module tb_pll_supervisor_rst_seq;
  logic clk = 1'b0, rst_n = 1'b0, lock = 1'b0, frc = 1'b0;
  logic resetb, bypass, ready, fault;
  logic [1:0] sys;
  logic [3:0] retry;
  logic [7:0] loss;
  int checks = 0, errors = 0;

  pll_supervisor_rst_seq #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
    .RST_STRETCH_CYCLES(4), .RST_STAGE_GAP(2), .NUM_RST(2), .MAX_RETRIES(2)
  ) dut (
    .REFERENCECLK(clk), .RESET(rst_n), .PLL_LOCK(lock), .FORCE_RESTART(frc),
    .PLL_RESETB(resetb), .PLL_BYPASS(bypass), .SYS_RESETN(sys), .READY(ready),
    .FAULT(fault), .RETRY_CNT(retry), .LOSS_CNT(loss)
  );

  always #5 clk = ~clk;

  // reset released on a falling edge; that sample is cycle 0 of the sequence
  task automatic do_reset(input logic l);
    rst_n = 1'b0; lock = l; frc = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; lock = 1'b0; frc = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({resetb, bypass, sys, ready, fault} !== 6'b0) begin errors++; $display("FAIL reset_outs: got %b want 000000", {resetb, bypass, sys, ready, fault}); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry); end
    checks++; if (loss !== 8'd0) begin errors++; $display("FAIL reset_loss: got %0d want 0", loss); end
  endtask

  task automatic test_clean_lock;
    int low, n;
    logic early;
    logic [1:0] exp;
    do_reset(1'b0);
    low = 0;
    for (n = 0; n < 20 && !resetb; n++) begin low++; @(negedge clk); end
    checks++; if (low != 4) begin errors++; $display("FAIL clean_rst_pulse: got %0d cycles want 4", low); end
    repeat (5) @(negedge clk);
    lock = 1'b1;
    early = 1'b0;
    for (n = 1; n <= 10; n++) begin @(negedge clk); if (ready) early = 1'b1; end
    checks++; if (early) begin errors++; $display("FAIL clean_ready_early: got 1 want 0"); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clean_ready: got %b want 1", ready); end
    checks++; if (sys !== 2'b00) begin errors++; $display("FAIL clean_sys_entry: got %b want 00", sys); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL clean_retry: got %0d want 0", retry); end
    for (n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n >= 3) begin
        exp = n >= 6 ? 2'b11 : n >= 4 ? 2'b01 : 2'b00;
        checks++; if (sys !== exp) begin errors++; $display("FAIL clean_stage_%0d: got %b want %b", n, sys, exp); end
      end
    end
    repeat (10) @(negedge clk);
    checks++; if ({ready, sys} !== 3'b111) begin errors++; $display("FAIL clean_hold: got %b want 111", {ready, sys}); end
  endtask

  task automatic test_single_timeout;
    int low, n;
    do_reset(1'b0);
    for (n = 0; n < 20 && !resetb; n++) @(negedge clk);
    repeat (19) @(negedge clk);
    checks++; if ({resetb, retry} !== 5'b1_0000) begin errors++; $display("FAIL to_before: got resetb=%b retry=%0d want 1/0", resetb, retry); end
    @(negedge clk);
    checks++; if ({resetb, retry} !== 5'b0_0001) begin errors++; $display("FAIL to_expire: got resetb=%b retry=%0d want 0/1", resetb, retry); end
    low = 0;
    for (n = 0; n < 20 && !resetb; n++) begin low++; @(negedge clk); end
    checks++; if (low != 4) begin errors++; $display("FAIL to_rst_pulse: got %0d cycles want 4", low); end
    lock = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if ({ready, retry} !== 5'b0_0001) begin errors++; $display("FAIL to_stable: got ready=%b retry=%0d want 0/1", ready, retry); end
    @(negedge clk);
    checks++; if ({ready, retry} !== 5'b1_0000) begin errors++; $display("FAIL to_run: got ready=%b retry=%0d want 1/0", ready, retry); end
  endtask

  task automatic test_glitchy;
    int n;
    logic early;
    do_reset(1'b0);
    for (n = 0; n < 20 && !resetb; n++) @(negedge clk);
    lock = 1'b1;
    repeat (5) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    early = 1'b0;
    for (n = 7; n <= 16; n++) begin @(negedge clk); if (ready) early = 1'b1; end
    checks++; if (early) begin errors++; $display("FAIL glitch_early: got 1 want 0"); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_run: got %b want 1", ready); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL glitch_retry: got %0d want 0", retry); end
  endtask

  task automatic test_lock_loss;
    int n, exp;
    repeat (8) @(negedge clk);
    checks++; if ({ready, sys} !== 3'b111) begin errors++; $display("FAIL loss_pre: got %b want 111", {ready, sys}); end
    lock = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({ready, sys} !== 3'b111) begin errors++; $display("FAIL loss_sync: got %b want 111", {ready, sys}); end
    @(negedge clk);
    checks++; if ({resetb, ready, sys} !== 4'b0000) begin errors++; $display("FAIL loss_drop: got %b want 0000", {resetb, ready, sys}); end
    checks++; if (loss !== 8'd1) begin errors++; $display("FAIL loss_cnt1: got %0d want 1", loss); end
    exp = 1;
    for (int k = 0; k < 300; k++) begin
      lock = 1'b1;
      for (n = 0; n < 40 && !ready; n++) @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_relock_%0d: got %b want 1", k, ready); end
      lock = 1'b0;
      repeat (3) @(negedge clk);
      exp = exp == 255 ? 255 : exp + 1;
      checks++; if (loss !== 8'(exp)) begin errors++; $display("FAIL loss_cnt_%0d: got %0d want %0d", k, loss, exp); end
    end
  endtask

  task automatic test_retry_exhaust;
    logic [1:0] exp;
    do_reset(1'b0);
    repeat (47) @(negedge clk);
    checks++; if ({fault, retry} !== 5'b0_0001) begin errors++; $display("FAIL ex_second: got fault=%b retry=%0d want 0/1", fault, retry); end
    @(negedge clk);
    checks++; if ({fault, bypass, resetb, ready, sys} !== 6'b111000) begin errors++; $display("FAIL ex_fallback: got %b want 111000", {fault, bypass, resetb, ready, sys}); end
    checks++; if (retry !== 4'd2) begin errors++; $display("FAIL ex_retry: got %0d want 2", retry); end
    for (int n = 49; n <= 54; n++) begin
      @(negedge clk);
      if (n >= 51) begin
        exp = n >= 54 ? 2'b11 : n >= 52 ? 2'b01 : 2'b00;
        checks++; if (sys !== exp) begin errors++; $display("FAIL ex_stage_%0d: got %b want %b", n, sys, exp); end
      end
    end
    lock = 1'b1;
    repeat (20) @(negedge clk);
    lock = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({fault, bypass, ready, sys} !== 5'b11011 || loss !== 8'd0) begin errors++; $display("FAIL ex_ignore_lock: got %b loss=%0d want 11011 loss=0", {fault, bypass, ready, sys}, loss); end
    frc = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    checks++; if ({fault, bypass, resetb, sys} !== 5'b00000) begin errors++; $display("FAIL ex_force: got %b want 00000", {fault, bypass, resetb, sys}); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL ex_force_retry: got %0d want 0", retry); end
  endtask

  task automatic test_edge_cases;
    int n;
    do_reset(1'b0);
    for (n = 0; n < 60 && retry == 4'd0; n++) @(negedge clk);
    lock = 1'b1;
    for (n = 0; n < 20 && !resetb; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if ({resetb, ready, retry} !== 6'b10_0001) begin errors++; $display("FAIL edge_stable: got resetb=%b ready=%b retry=%0d want 1/0/1", resetb, ready, retry); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({resetb, bypass, sys, ready, fault} !== 6'b0 || retry !== 4'd0) begin errors++; $display("FAIL edge_async_rst: got %b retry=%0d want 000000 retry=0", {resetb, bypass, sys, ready, fault}, retry); end
    do_reset(1'b1);
    for (n = 0; n < 40 && !ready; n++) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL edge_run: got %b want 1", ready); end
    lock = 1'b0;
    repeat (2) @(negedge clk);
    frc = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    checks++; if (loss !== 8'd0) begin errors++; $display("FAIL edge_force_loss: got %0d want 0", loss); end
    checks++; if ({resetb, ready, sys, retry} !== 8'b0) begin errors++; $display("FAIL edge_force_state: got %b want 00000000", {resetb, ready, sys, retry}); end
  endtask

  initial begin
    test_reset;
    test_clean_lock;
    test_single_timeout;
    test_glitchy;
    test_lock_loss;
    test_retry_exhaust;
    test_edge_cases;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
